// File: rtl/mdr_sized_ctrl_if.sv
// rtl/mdr_sized_ctrl_if.sv - bus-side and memory-side signal bundle of the sized memory data register
interface mdr_sized_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = $clog2(BW);

  logic                  enable;
  logic                  read;
  logic                  write;
  logic [1:0]            size;
  logic                  sign_ext;
  logic [AW-1:0]         addr_lo;
  logic [DATA_WIDTH-1:0] FromBus;
  logic [DATA_WIDTH-1:0] BusMuxIn;
  logic                  mem_req;
  logic                  mem_we;
  logic [BW-1:0]         mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport slave (
    input  enable, read, write, size, sign_ext, addr_lo, FromBus, mem_rdata, mem_ack,
    output BusMuxIn, mem_req, mem_we, mem_be, mem_wdata, busy, done, err
  );

  modport master (
    output enable, read, write, size, sign_ext, addr_lo, FromBus, mem_rdata, mem_ack,
    input  BusMuxIn, mem_req, mem_we, mem_be, mem_wdata, busy, done, err
  );
endinterface

// File: rtl/mdr_sized_ctrl.sv
// rtl/mdr_sized_ctrl.sv - memory data register with sized, lane-steered memory handshake
module mdr_sized_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0,
  parameter int                    TIMEOUT    = 15
) (
  input  logic             clock,
  input  logic             clear,
  mdr_sized_ctrl_if.slave  bus
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int AW = $clog2(BW);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAIL} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] q;
  logic [1:0]            size_q;
  logic [AW-1:0]         off_q;
  logic                  op_q;
  logic                  sign_q;
  logic [7:0]            cnt;
  logic                  req_r, we_r, busy_r, done_r, err_r;

  logic                  aligned;
  logic [DATA_WIDTH-1:0] lane, up, ld_val;
  logic signed [DATA_WIDTH-1:0] sx;
  logic [6:0]            sh;
  logic [BW-1:0]         be;
  logic [DATA_WIDTH-1:0] wdata;

  // dword is only a legal size when the register is 64 bits wide
  always_comb begin
    aligned = 1'b0;
    case (bus.size)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~bus.addr_lo[0];
      2'b10:   aligned = (bus.addr_lo[1:0] == 2'b00);
      default: aligned = (DATA_WIDTH == 64) && (bus.addr_lo == '0);
    endcase
  end

  // Shift the addressed lane to the top, then back down logically or arithmetically
  always_comb begin
    lane = bus.mem_rdata >> {off_q, 3'b000};
    sh   = 7'd0;
    case (size_q)
      2'b00:   sh = 7'(DATA_WIDTH - 8);
      2'b01:   sh = 7'(DATA_WIDTH - 16);
      2'b10:   sh = 7'(DATA_WIDTH - 32);
      default: sh = 7'd0;
    endcase
    up     = lane << sh;
    sx     = $signed(up) >>> sh;
    ld_val = sign_q ? $unsigned(sx) : (up >> sh);
  end

  always_comb begin
    be    = '0;
    wdata = '0;
    case (size_q)
      2'b00: begin
        be    = BW'(1) << off_q;
        wdata = {BW{q[7:0]}};
      end
      2'b01: begin
        be    = BW'(3) << off_q;
        wdata = {(DATA_WIDTH/16){q[15:0]}};
      end
      2'b10: begin
        be    = BW'(15) << off_q;
        wdata = {(DATA_WIDTH/32){q[31:0]}};
      end
      default: begin
        be    = '1;
        wdata = q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= IDLE;
      q      <= INIT;
      size_q <= 2'b00;
      off_q  <= '0;
      op_q   <= 1'b0;
      sign_q <= 1'b0;
      cnt    <= 8'd0;
      req_r  <= 1'b0;
      we_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            size_q <= bus.size;
            off_q  <= bus.addr_lo;
            sign_q <= bus.sign_ext;
            op_q   <= ~bus.read;
            busy_r <= 1'b1;
            if (aligned) begin
              state <= ACCESS;
              cnt   <= 8'd0;
              req_r <= 1'b1;
              we_r  <= ~bus.read;
            end else begin
              state <= FAIL;
              err_r <= 1'b1;
            end
          end else if (bus.enable) begin
            q <= bus.FromBus;
          end
        end
        ACCESS: begin
          if (bus.mem_ack) begin
            if (!op_q) q <= ld_val;
            state  <= DONE;
            done_r <= 1'b1;
            req_r  <= 1'b0;
            we_r   <= 1'b0;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state <= FAIL;
            err_r <= 1'b1;
            req_r <= 1'b0;
            we_r  <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE, FAIL: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.BusMuxIn  = q;
  assign bus.mem_req   = req_r;
  assign bus.mem_we    = we_r;
  assign bus.mem_be    = req_r ? be : '0;
  assign bus.mem_wdata = req_r ? wdata : '0;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
endmodule

// File: tb/tb_mdr_sized_ctrl.sv
// tb/tb_mdr_sized_ctrl.sv - scoreboard bench for the sized memory data register
module tb_mdr_sized_ctrl;
  localparam int T = 4;

  logic clock = 1'b0;
  logic clear = 1'b1;
  always #5 clock = ~clock;

  mdr_sized_ctrl_if #(.DATA_WIDTH(32)) bus ();

  mdr_sized_ctrl #(.DATA_WIDTH(32), .INIT(32'h0), .TIMEOUT(T)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] q;
    bit          chk_mem;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          req_cycles;
    int          exp_edge;
  } exp_t;

  exp_t        exp_q[$];
  int          vec = 0;
  int          errs = 0;
  int          edge_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] mdl_q = 32'h0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vec++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT reports completion or error
  always @(negedge clock) begin
    if (clear) begin
      req_cnt = 0;
    end else begin
      if (bus.mem_req) begin
        req_cnt++;
        if (req_cnt == 1 && exp_q.size() > 0 && exp_q[0].chk_mem) begin
          chk("mem_we", bus.mem_we, exp_q[0].we);
          chk("mem_be", bus.mem_be, exp_q[0].be);
          chk("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
        end
      end
      if (bus.done || bus.err) begin
        if (exp_q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL unexpected_resp got done=%0b err=%0b want none", bus.done, bus.err);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err", bus.err, e.is_err);
          chk("done", bus.done, !e.is_err);
          chk("q", bus.BusMuxIn, e.q);
          chk("req_cycles", req_cnt, e.req_cycles);
          chk("resp_edge", edge_cnt, e.exp_edge);
        end
        req_cnt = 0;
      end
    end
  end

  function automatic logic [31:0] mdl_load(logic [31:0] rd, int sz, int off, bit sxt);
    int          nb;
    logic [31:0] mask, v;
    nb   = 1 << sz;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
    v    = (rd >> (8 * off)) & mask;
    if (sxt && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_enable(input logic [31:0] data);
    @(negedge clock);
    bus.enable  = 1'b1;
    bus.FromBus = data;
    @(posedge clock);
    @(negedge clock);
    bus.enable = 1'b0;
    mdl_q = data;
    chk("enable_q", bus.BusMuxIn, mdl_q);
    chk("enable_busy", bus.busy, 1'b0);
  endtask

  task automatic do_op(input bit is_rd, input int sz, input int off, input bit sxt,
                       input logic [31:0] rdata, input int waits, input bit intf);
    exp_t e;
    int   nb, c;
    bit   legal, tmo;
    nb    = 1 << sz;
    legal = (sz != 3) && (off % nb == 0);
    tmo   = legal && (waits >= T);
    @(negedge clock);
    e.is_err     = !legal || tmo;
    e.chk_mem    = legal;
    e.we         = !is_rd;
    e.be         = 4'(((1 << nb) - 1) << off);
    for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = mdl_q[8*(i % nb) +: 8];
    e.req_cycles = !legal ? 0 : (tmo ? T : waits + 1);
    e.exp_edge   = edge_cnt + 1 + e.req_cycles;
    if (legal && !tmo && is_rd) mdl_q = mdl_load(rdata, sz, off, sxt);
    e.q = mdl_q;
    exp_q.push_back(e);
    bus.read      = is_rd;
    bus.write     = !is_rd;
    bus.size      = 2'(sz);
    bus.addr_lo   = 2'(off);
    bus.sign_ext  = sxt;
    bus.mem_rdata = rdata;
    if (intf) begin
      bus.enable  = 1'b1;
      bus.FromBus = $urandom;
    end
    @(posedge clock);
    @(negedge clock);
    bus.read   = 1'b0;
    bus.write  = 1'b0;
    bus.enable = 1'b0;
    for (c = 1; c <= 25; c++) begin
      if (!bus.busy) break;
      bus.mem_ack = legal && (c == waits + 1);
      if (intf) begin
        bus.enable  = 1'b1;
        bus.write   = 1'b1;
        bus.FromBus = $urandom;
      end
      @(posedge clock);
      @(negedge clock);
      bus.mem_ack = 1'b0;
    end
    bus.enable = 1'b0;
    bus.write  = 1'b0;
    if (c > 25) begin
      vec++;
      errs++;
      $display("FAIL op_timeout got busy=1 want busy=0 within 25 cycles");
    end
  endtask

  initial begin
    bus.enable    = 1'b0;
    bus.read      = 1'b0;
    bus.write     = 1'b0;
    bus.size      = 2'b00;
    bus.sign_ext  = 1'b0;
    bus.addr_lo   = 2'b00;
    bus.FromBus   = 32'h0;
    bus.mem_rdata = 32'h0;
    bus.mem_ack   = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    chk("rst_q", bus.BusMuxIn, 32'h0);
    chk("rst_outs", {bus.mem_req, bus.mem_we, bus.busy, bus.done, bus.err}, 5'b0);
    chk("rst_be_wd", {bus.mem_be, bus.mem_wdata}, 36'h0);

    do_enable(32'hDEADBEEF);
    do_op(1'b1, 0, 2, 1'b1, 32'h1280_3456, 0, 1'b0);
    do_op(1'b1, 1, 2, 1'b0, 32'hBEEF_0000, 3, 1'b0);
    do_enable(32'h0000_00A5);
    do_op(1'b0, 0, 3, 1'b0, 32'h0, 0, 1'b0);
    do_op(1'b1, 2, 1, 1'b0, 32'h1234_5678, 0, 1'b0);
    do_op(1'b1, 3, 0, 1'b0, 32'h1234_5678, 0, 1'b0);
    do_op(1'b1, 2, 0, 1'b0, 32'h1234_5678, 9, 1'b1);
    do_op(1'b0, 2, 0, 1'b0, 32'h0, 1, 1'b1);

    // Reset in the middle of an access must drop mem_req asynchronously
    do_enable(32'h5555_AAAA);
    @(negedge clock);
    bus.read = 1'b1;
    bus.size = 2'b10;
    bus.addr_lo = 2'b00;
    @(posedge clock);
    @(negedge clock);
    bus.read = 1'b0;
    @(posedge clock);
    #1;
    chk("pre_clear_req", bus.mem_req, 1'b1);
    #2;
    clear = 1'b1;
    #1;
    chk("clear_req", bus.mem_req, 1'b0);
    chk("clear_q", bus.BusMuxIn, 32'h0);
    chk("clear_busy", bus.busy, 1'b0);
    mdl_q = 32'h0;
    @(posedge clock);
    #1;
    clear = 1'b0;

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_enable($urandom);
      end else begin
        do_op($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 5),
              $urandom_range(0, 3) == 0);
      end
    end

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/mdr_sized_ctrl.md
Name: mdr_sized_ctrl

Overview:
Memory data register with a built-in memory handshake controller. It supports byte, halfword and word accesses, little-endian lane steering, and sign or zero extension on loads. It also provides wait-state handling and a bounded timeout. It sits between the internal bus (BusMuxIn / FromBus) and the memory port, and replaces the plain single-cycle data register on the memory path.

Parameters:
DATA_WIDTH, 32, register and memory data width; legal values 32 or 64.
INIT, 0, value loaded into q on reset.
TIMEOUT, 15, maximum cycles spent in ACCESS without mem_ack; legal range 1..255.

Ports:
clock  in  1  system clock; all state changes on the rising edge.
clear  in  1  asynchronous, active-high reset.
enable  in  1  load q from FromBus; honoured in IDLE only.
read  in  1  start a memory load; honoured in IDLE only.
write  in  1  start a memory store of q; honoured in IDLE only.
size  in  2  access size: 00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_WIDTH=64).
sign_ext  in  1  load only: 1 sign-extends the loaded value, 0 zero-extends it.
addr_lo  in  log2(DATA_WIDTH/8)  byte offset of the access; captured at command.
FromBus  in  DATA_WIDTH  data from the internal bus.
BusMuxIn  out  DATA_WIDTH  q, driven to the bus mux.
mem_req  out  1  memory request.
mem_we  out  1  1 = store, 0 = load.
mem_be  out  DATA_WIDTH/8  byte enables.
mem_wdata  out  DATA_WIDTH  store data, replicated across lanes.
mem_rdata  in  DATA_WIDTH  load data from memory.
mem_ack  in  1  memory completion, sampled at each rising edge while in ACCESS.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse on successful completion.
err  out  1  one-cycle pulse on misalignment, illegal size or timeout.

Behaviour:
- Reset (async, clear=1): q=INIT; state=IDLE; size, offset, op, sign_ext and the wait counter all reset to 0. All outputs are then 0 except BusMuxIn=INIT.
- States: IDLE, ACCESS, DONE, FAIL.
- IDLE command priority: read, then write, then enable. Only one action is taken per cycle.
  - enable alone: q<=FromBus on that edge; state stays IDLE.
  - read or write: latch size, addr_lo, sign_ext and op.
    - Alignment check: half requires addr_lo[0]=0; word requires addr_lo[1:0]=0; dword requires addr_lo=0; byte is always aligned.
    - Misaligned or illegal size: go to FAIL; no memory request is issued.
    - Otherwise go to ACCESS with wait counter=0.
- ACCESS: mem_req=1; mem_we=op; mem_be and mem_wdata are driven from the latched fields and q.
  - Byte enables:
    - byte: mem_be = 1<<off.
    - half: mem_be = 2'b11<<off.
    - word: mem_be = 4'hF<<off.
    - dword: mem_be = all ones.
  - Store data: mem_wdata replicates the low byte, half or word of q across all lanes; dword drives q as-is.
  - mem_ack=1 at an edge:
    - Load: take the lane mem_rdata[8*off +: N], extend it to DATA_WIDTH per sign_ext, and write it to q.
    - Store: q is unchanged.
    - Either way, go to DONE.
  - mem_ack=0 at an edge: increment the counter. When the counter equals TIMEOUT-1 at that edge, go to FAIL with q unchanged.
- DONE: done=1 for one cycle, then IDLE. FAIL: err=1 for one cycle, then IDLE.
- Command handling outside IDLE: read, write and enable are ignored in ACCESS, DONE and FAIL, and FromBus is not sampled there.
- Latency: a command at edge 0 raises mem_req during cycle 1. Zero-wait ack at edge 1 gives done in cycle 2, with q updated at edge 1. A new command is accepted at edge 2 at the earliest.
- Timeout cycle count: mem_req stays asserted for exactly TIMEOUT cycles before FAIL.
- Mid-access reset: clear during ACCESS drops mem_req immediately (async), returns to IDLE and sets q=INIT.
- Outside ACCESS: mem_req=0, mem_we=0, mem_be=0, mem_wdata=0.

Test Plan:
- Reset and bus load: clear pulse, then BusMuxIn=0. enable=1 with FromBus=32'hDEADBEEF, then BusMuxIn=32'hDEADBEEF after 1 edge; busy stays 0.
- Signed byte load: read, size=00, addr_lo=2, sign_ext=1; mem_rdata=32'h1280_3456, ack on first cycle. Required: mem_be=4'b0100; q=32'hFFFFFF80; done pulses in cycle 2.
- Unsigned half load with waits: size=01, addr_lo=2, sign_ext=0, ack after 3 wait cycles, mem_rdata=32'hBEEF0000. Required: mem_req high for 4 cycles; q=32'h0000BEEF; busy high throughout.
- Byte store: q=32'h000000A5, write, size=00, addr_lo=3. Required: mem_we=1, mem_be=4'b1000, mem_wdata=32'hA5A5A5A5; q is unchanged after done.
- Misaligned word: read, size=10, addr_lo=1. Required: mem_req never asserts; err pulses 1 cycle; q unchanged. Repeat with size=11 at DATA_WIDTH=32: err.
- Timeout and interference: TIMEOUT=4, read, no ack. Required: mem_req high exactly 4 cycles, then err. Also assert enable and write during ACCESS: both ignored. Assert clear mid-access: mem_req drops the same cycle and q=INIT.
